// File: rtl/csa_pkg.sv
// Shared types and sizes for the carry-save operand collector.
package csa_pkg;

  localparam int unsigned CSA_WIDTH   = 20;
  localparam int unsigned CSA_NUM_OPS = 9;
  localparam int unsigned OP_CNT_W    = 4;
  localparam int unsigned CSA_ACC_W   = CSA_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SUM,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic [CSA_WIDTH-1:0] data;
  } csa_result_t;

endpackage

// File: rtl/carry_save_adder.sv
// Nine-input 3:2 carry-save reduction tree with a truncating final adder.
module carry_save_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH
) (
  input  logic [CSA_NUM_OPS-1:0][WIDTH-1:0] ops,
  output logic [WIDTH-1:0]                  sum
);

  // Returns {carry, sum}; the carry is pre-shifted and its MSB dropped (mod 2^WIDTH).
  function automatic logic [2*WIDTH-1:0] csa3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] cy;
    maj = (a & b) | (a & c) | (b & c);
    cy  = maj << 1;
    return {cy, a ^ b ^ c};
  endfunction

  logic [WIDTH-1:0] s1a, c1a, s1b, c1b, s1c, c1c;
  logic [WIDTH-1:0] s2a, c2a, s2b, c2b;
  logic [WIDTH-1:0] s3, c3, s4, c4;

  // 9 -> 6 -> 4 -> 3 -> 2 vectors, then one carry-propagate add.
  always_comb begin
    {c1a, s1a} = csa3(ops[0], ops[1], ops[2]);
    {c1b, s1b} = csa3(ops[3], ops[4], ops[5]);
    {c1c, s1c} = csa3(ops[6], ops[7], ops[8]);
    {c2a, s2a} = csa3(s1a, c1a, s1b);
    {c2b, s2b} = csa3(c1b, s1c, c1c);
    {c3,  s3 } = csa3(s2a, c2a, s2b);
    {c4,  s4 } = csa3(s3, c3, c2b);
    sum        = s4 + c4;
  end

endmodule

// File: rtl/csa_operand_collector.sv
// Serial-to-parallel front end for the 9-operand carry-save adder tree.
// Optional overflow flag built when CSA_OVF_FLAG_EN is defined.
module csa_operand_collector
  import csa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CSA_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CSA_WIDTH-1:0] out_data,
  output logic [OP_CNT_W-1:0]  op_count,
  output logic                 out_ovf
);

  state_t                                  state, state_nxt;
  logic [OP_CNT_W-1:0]                     op_count_nxt;
  logic                                    out_valid_nxt;
  logic                                    buf_we;
  logic                                    load_result;
  logic [CSA_NUM_OPS-1:0][CSA_WIDTH-1:0]   op_buf;
  csa_result_t                             result_q;
  logic [CSA_WIDTH-1:0]                    sum_c;
  logic                                    ovf_c;

  carry_save_adder #(.WIDTH(CSA_WIDTH)) u_tree (
    .ops (op_buf),
    .sum (sum_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_nxt;
  end

  // Next state and datapath controls; clear overrides every handshake.
  always_comb begin
    state_nxt     = state;
    op_count_nxt  = op_count;
    out_valid_nxt = out_valid;
    buf_we        = 1'b0;
    load_result   = 1'b0;
    if (clear) begin
      state_nxt     = ST_COLLECT;
      op_count_nxt  = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_valid && in_ready) begin
            buf_we       = 1'b1;
            op_count_nxt = op_count + OP_CNT_W'(1);
            if (op_count == OP_CNT_W'(CSA_NUM_OPS - 1)) state_nxt = ST_SUM;
          end
        end
        ST_SUM: begin
          load_result   = 1'b1;
          out_valid_nxt = 1'b1;
          state_nxt     = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
            op_count_nxt  = '0;
            state_nxt     = ST_COLLECT;
          end
        end
        default: state_nxt = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result_q  <= '0;
      op_buf    <= '0;
    end else begin
      op_count  <= op_count_nxt;
      in_ready  <= (state_nxt == ST_COLLECT);
      out_valid <= out_valid_nxt;
      if (clear)            result_q <= '0;
      else if (load_result) result_q <= '{ovf: ovf_c, data: sum_c};
      if (buf_we) op_buf[op_count] <= in_data;
    end
  end

`ifdef CSA_OVF_FLAG_EN
  logic [CSA_ACC_W-1:0] acc;
  logic                 acc_clr;

  assign acc_clr = clear | (state == ST_HOLD && out_valid && out_ready);

  // Wide shadow sum of accepted operands; bits above WIDTH flag overflow.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) acc <= '0;
    else if (buf_we)    acc <= acc + CSA_ACC_W'(in_data);
  end

  assign ovf_c = |acc[CSA_ACC_W-1:CSA_WIDTH];
`else
  assign ovf_c = 1'b0;
`endif

  assign out_data = result_q.data;
  assign out_ovf  = result_q.ovf;

endmodule
